// File: rtl/relogio_if.sv
// relogio_if: BCD digit bus between the relogio clock core and display logic.
// Compile-time option: RELOGIO_DAY_PULSE_EN adds the day_pulse signal.
interface relogio_if;
    logic [3:0] dhourq;
    logic [3:0] uhourq;
    logic [3:0] dminq;
    logic [3:0] uminq;
`ifdef RELOGIO_DAY_PULSE_EN
    logic       day_pulse;

    modport master (output dhourq, output uhourq, output dminq, output uminq, output day_pulse);
    modport slave  (input  dhourq, input  uhourq, input  dminq, input  uminq, input  day_pulse);
`else
    modport master (output dhourq, output uhourq, output dminq, output uminq);
    modport slave  (input  dhourq, input  uhourq, input  dminq, input  uminq);
`endif
endinterface

// File: rtl/relogio.sv
// relogio: 24-hour HH:MM clock core with BCD digit outputs.
// The minute advance comes from an internal prescaler of TICKS_PER_MIN clk edges.
// Compile-time option: RELOGIO_DAY_PULSE_EN adds a one-cycle day_pulse on 23:59 -> 00:00.
module relogio #(
    parameter int unsigned TICKS_PER_MIN = 1
) (
    input  logic      clk,
    input  logic      reset,
    relogio_if.master bus
);

    localparam int unsigned   PW   = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_MIN - 1);

    logic [PW-1:0] presc_q;
    logic          tick;

    logic [3:0] dh_q, uh_q, dm_q, um_q;
    logic [3:0] dh_d, uh_d, dm_d, um_d;
    logic       legal;

    assign tick = (presc_q == LAST);

    // Prescaler: counts 0..TICKS_PER_MIN-1 and wraps on the tick cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Next-state digits: cascaded BCD counters, illegal states collapse to 00:00.
    always_comb begin
        dh_d  = dh_q;
        uh_d  = uh_q;
        dm_d  = dm_q;
        um_d  = um_q;
        legal = (dh_q <= 4'd2) && (dm_q <= 4'd5) && (um_q <= 4'd9) &&
                ((dh_q == 4'd2) ? (uh_q <= 4'd3) : (uh_q <= 4'd9));
        if (tick) begin
            if (!legal) begin
                dh_d = '0;
                uh_d = '0;
                dm_d = '0;
                um_d = '0;
            end else if (um_q != 4'd9) begin
                um_d = um_q + 4'd1;
            end else begin
                um_d = '0;
                if (dm_q != 4'd5) begin
                    dm_d = dm_q + 4'd1;
                end else begin
                    dm_d = '0;
                    if ((dh_q == 4'd2) && (uh_q == 4'd3)) begin
                        dh_d = '0;
                        uh_d = '0;
                    end else if (uh_q == 4'd9) begin
                        uh_d = '0;
                        dh_d = dh_q + 4'd1;
                    end else begin
                        uh_d = uh_q + 4'd1;
                    end
                end
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dh_q <= '0;
            uh_q <= '0;
            dm_q <= '0;
            um_q <= '0;
        end else begin
            dh_q <= dh_d;
            uh_q <= uh_d;
            dm_q <= dm_d;
            um_q <= um_d;
        end
    end

    assign bus.dhourq = dh_q;
    assign bus.uhourq = uh_q;
    assign bus.dminq  = dm_q;
    assign bus.uminq  = um_q;

`ifdef RELOGIO_DAY_PULSE_EN
    logic day_wrap;
    logic day_q;

    // Only a legal 23:59 advancing on a tick counts as a day boundary.
    assign day_wrap = tick && legal && (dh_q == 4'd2) && (uh_q == 4'd3) &&
                      (dm_q == 4'd5) && (um_q == 4'd9);

    // Day pulse register: high for the single cycle following the wrap edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            day_q <= 1'b0;
        end else begin
            day_q <= day_wrap;
        end
    end

    assign bus.day_pulse = day_q;
`endif

endmodule

// File: tb/tb_relogio.sv
// tb_relogio: directed vectors for relogio with TICKS_PER_MIN = 1 and 4.
// Honours RELOGIO_DAY_PULSE_EN when defined.
module tb_relogio;

    logic clk;
    logic rst1;
    logic rst4;

    relogio_if if1 ();
    relogio_if if4 ();

    relogio #(.TICKS_PER_MIN(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1));
    relogio #(.TICKS_PER_MIN(4)) dut4 (.clk(clk), .reset(rst4), .bus(if4));

    initial clk = 1'b0;
    always #30 clk = ~clk;

    int unsigned nvec;
    int unsigned nmis;

    typedef struct {
        int unsigned edges;   // rising edges since reset release
        logic [15:0] exp1;    // HHMM for TICKS_PER_MIN = 1
        logic [15:0] exp4;    // HHMM for TICKS_PER_MIN = 4
        logic        dp1;     // day_pulse expected on dut1
    } vec_t;

    vec_t tbl[10];

    function automatic logic [15:0] hhmm1();
        return {if1.dhourq, if1.uhourq, if1.dminq, if1.uminq};
    endfunction

    function automatic logic [15:0] hhmm4();
        return {if4.dhourq, if4.uhourq, if4.dminq, if4.uminq};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        rst1 = 1'b0;
        rst4 = 1'b0;

        tbl[0] = '{edges: 1,    exp1: 16'h0001, exp4: 16'h0000, dp1: 1'b0};
        tbl[1] = '{edges: 10,   exp1: 16'h0010, exp4: 16'h0002, dp1: 1'b0};
        tbl[2] = '{edges: 60,   exp1: 16'h0100, exp4: 16'h0015, dp1: 1'b0};
        tbl[3] = '{edges: 137,  exp1: 16'h0217, exp4: 16'h0034, dp1: 1'b0};
        tbl[4] = '{edges: 600,  exp1: 16'h1000, exp4: 16'h0230, dp1: 1'b0};
        tbl[5] = '{edges: 1439, exp1: 16'h2359, exp4: 16'h0559, dp1: 1'b0};
        tbl[6] = '{edges: 1440, exp1: 16'h0000, exp4: 16'h0600, dp1: 1'b1};
        tbl[7] = '{edges: 1441, exp1: 16'h0001, exp4: 16'h0600, dp1: 1'b0};
        tbl[8] = '{edges: 1499, exp1: 16'h0059, exp4: 16'h0614, dp1: 1'b0};
        tbl[9] = '{edges: 1500, exp1: 16'h0100, exp4: 16'h0615, dp1: 1'b0};

        // Reset held low while the clock runs.
        step(3);
        chk("reset_hold_n1", hhmm1(), 16'h0000);
        chk("reset_hold_n4", hhmm4(), 16'h0000);
`ifdef RELOGIO_DAY_PULSE_EN
        chk("reset_hold_dp", {15'b0, if1.day_pulse}, 16'h0000);
`endif

        @(negedge clk);
        rst1 = 1'b1;
        rst4 = 1'b1;

        begin
            int unsigned cur;
            cur = 0;
            for (int i = 0; i < 10; i++) begin
                step(tbl[i].edges - cur);
                cur = tbl[i].edges;
                chk($sformatf("n1_edge%0d", tbl[i].edges), hhmm1(), tbl[i].exp1);
                chk($sformatf("n4_edge%0d", tbl[i].edges), hhmm4(), tbl[i].exp4);
`ifdef RELOGIO_DAY_PULSE_EN
                chk($sformatf("dp_edge%0d", tbl[i].edges), {15'b0, if1.day_pulse}, {15'b0, tbl[i].dp1});
`endif
            end
        end

        // Asynchronous reset in the middle of a count on dut1.
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        step(137);
        chk("midrst_pre", hhmm1(), 16'h0217);
        #10 rst1 = 1'b0;
        #1;
        chk("midrst_async", hhmm1(), 16'h0000);
        #5 rst1 = 1'b1;
        step(1);
        chk("midrst_next", hhmm1(), 16'h0001);

        // Prescaler corners on dut4.
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        step(3);
        chk("n4_e3", hhmm4(), 16'h0000);
        step(1);
        chk("n4_e4", hhmm4(), 16'h0001);
        step(236);
        chk("n4_e240", hhmm4(), 16'h0100);
        step(5519);
        chk("n4_e5759", hhmm4(), 16'h2359);
        step(1);
        chk("n4_e5760", hhmm4(), 16'h0000);
`ifdef RELOGIO_DAY_PULSE_EN
        chk("n4_dp_e5760", {15'b0, if4.day_pulse}, 16'h0001);
`endif
        step(1);
        chk("n4_e5761", hhmm4(), 16'h0000);
`ifdef RELOGIO_DAY_PULSE_EN
        chk("n4_dp_e5761", {15'b0, if4.day_pulse}, 16'h0000);
`endif
        step(3);
        chk("n4_e5764", hhmm4(), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/relogio.md
# relogio

Synchronous 24-hour digital clock core counting hours and minutes in BCD, 00:00 to 23:59 and wrapping. Each minute advance is derived from the system clock through an internal prescaler. Sits below display/driver logic, which consumes its four BCD digit outputs directly.

## Interface
- `TICKS_PER_MIN`, default 1: number of `clk` rising edges per minute advance; legal range 1 to 2^24.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state while low.
- `dhourq` output 4: tens-of-hours BCD digit, range 0–2.
- `uhourq` output 4: units-of-hours BCD digit, range 0–9, or 0–3 when `dhourq` = 2.
- `dminq` output 4: tens-of-minutes BCD digit, range 0–5.
- `uminq` output 4: units-of-minutes BCD digit, range 0–9.
- `day_pulse` output 1: present only with `RELOGIO_DAY_PULSE_EN`; see Configuration.

## Operation
- **Prescaler:** counter of width ceil(log2(TICKS_PER_MIN)), minimum 1 bit.
  - Counts 0 to TICKS_PER_MIN-1 and wraps.
  - Minute tick is asserted in the cycle where the prescaler equals TICKS_PER_MIN-1.
  - With TICKS_PER_MIN = 1, the tick is asserted every cycle.
- **Digit update on minute tick:** cascaded BCD counters.
  - `uminq` increments. At 9 it returns to 0 and carries into `dminq`.
  - `dminq` at 5 with a carry in returns to 0 and carries into the hours.
  - Hours: `uhourq` increments. At 9 it returns to 0 and increments `dhourq`.
  - At 23 with a carry in, both hour digits return to 0.
- **Full wrap:** 23:59 followed by a tick gives 00:00 in a single step.
- **Illegal digit states:** any state outside the legal ranges, which is unreachable in normal operation, is replaced by 00:00 on the next tick.
- **No minute tick:** all digits hold their values.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- **Reset assertion:** while `reset` is low, the prescaler is 0 and all digits are 0 (00:00), independent of `clk`.
- **Reset mid-operation:** clears immediately and asynchronously to 00:00 with the prescaler at 0.
- **Reset release:** the counter restarts from 0, so the first rising edge after release counts as prescaler value 0.
- **Update latency:** digits change on the same rising edge where the tick is asserted.
  - With TICKS_PER_MIN = N, the k-th rising edge after reset release yields floor(k/N) minutes, modulo 1440.
  - With N = 1: edge 1 gives 00:01, edge 60 gives 01:00, edge 1440 gives 00:00.
- **Carries:** all carries resolve within one cycle; no intermediate values (for example 23:60 or 24:00) are ever visible.

## Configuration
- **`RELOGIO_DAY_PULSE_EN` defined:**
  - Adds output `day_pulse` (1 bit).
  - It is high for exactly one `clk` cycle, registered on the same edge where 23:59 becomes 00:00.
  - It is low during and after reset.
- **Not defined:**
  - The port and its logic are absent.
  - Digit behaviour is identical in both cases.

## Test plan
- **Reset:** hold `reset` low, toggle `clk` -> outputs stay 0,0,0,0. Release, then 1 edge (N=1) -> 0,0,0,1.
- **Minute carries (N=1):** 10 edges after reset -> 0,0,1,0. 60 edges -> 0,1,0,0. 600 edges -> 1,0,0,0.
- **Day wrap (N=1):** 1439 edges -> 2,3,5,9. Edge 1440 -> 0,0,0,0. With the macro defined, `day_pulse` is high only in that cycle. 1500 edges (90000 time units at 60-unit period) -> 0,1,0,0.
- **Reset mid-count:** after 137 edges (02:17), pulse `reset` low asynchronously between edges -> 0,0,0,0 immediately. Next edge -> 00:01.
- **Prescaler (TICKS_PER_MIN=4):** 3 edges -> 00:00. Edge 4 -> 00:01. 240 edges -> 01:00. 5760 edges -> 00:00.
